// File: rtl/pcie_drp_pkg.sv
// rtl/pcie_drp_pkg.sv - shared widths, op and state encodings for the PCIE_2_1 DRP master
package pcie_drp_pkg;

    localparam int DRP_ADDR_W = 9;
    localparam int DRP_DATA_W = 16;

    // Encoding 2'd3 is reserved and is decoded as OP_READ at command accept.
    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_RMW   = 2'd2
    } drp_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_STB,
        ST_RD_WAIT,
        ST_WR_STB,
        ST_WR_WAIT,
        ST_RESP
    } drp_state_e;

endpackage

// File: rtl/pcie_drp_timer.sv
// rtl/pcie_drp_timer.sv - clearable saturating wait counter with terminal flag
//
// Ports:
//   clk, rst_n  clock and async active-low reset
//   clr_i       return the count to zero
//   inc_i       count one waiting cycle
//   expire_o    this increment brings the count to LIMIT
module pcie_drp_timer #(
    parameter int LIMIT = 64,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != W'(LIMIT))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flag is raised combinationally so the master can leave WAIT in the
    // same cycle the count would reach LIMIT.
    assign expire_o = inc_i && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/pcie_drp_master.sv
// rtl/pcie_drp_master.sv - command sequencer driving the PCIE_2_1 DRP port
//
// Ports:
//   clk, rst_n                          DRP clock, async active-low reset
//   cmd_valid/cmd_ready                 command handshake
//   cmd_op/cmd_addr/cmd_wdata/cmd_mask  READ/WRITE/RMW command fields
//   rsp_valid/rsp_ready                 response handshake
//   rsp_data/rsp_timeout                value read (0 for WRITE) and timeout flag
//   drp_addr/drp_di/drp_en/drp_we       to DRPADDR/DRPDI/DRPEN/DRPWE
//   drp_do/drp_rdy                      from DRPDO/DRPRDY
//   stray_rdy                           sticky: drp_rdy seen with no access waiting
module pcie_drp_master
    import pcie_drp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [DRP_ADDR_W-1:0] cmd_addr,
    input  logic [DRP_DATA_W-1:0] cmd_wdata,
    input  logic [DRP_DATA_W-1:0] cmd_mask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DRP_DATA_W-1:0] rsp_data,
    output logic                  rsp_timeout,
    output logic [DRP_ADDR_W-1:0] drp_addr,
    output logic [DRP_DATA_W-1:0] drp_di,
    output logic                  drp_en,
    output logic                  drp_we,
    input  logic [DRP_DATA_W-1:0] drp_do,
    input  logic                  drp_rdy,
    output logic                  stray_rdy
);

    drp_state_e            state_q, state_d;
    drp_op_e               op_q, op_d;
    logic [DRP_ADDR_W-1:0] addr_q, addr_d;
    logic [DRP_DATA_W-1:0] wdata_q, wdata_d;
    logic [DRP_DATA_W-1:0] mask_q, mask_d;
    logic [DRP_DATA_W-1:0] di_q, di_d;
    logic [DRP_DATA_W-1:0] data_q, data_d;
    logic                  tmo_q, tmo_d;
    logic                  stray_q, stray_d;
    logic                  tmr_clr, tmr_inc, tmr_expire;

    pcie_drp_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (tmr_clr),
        .inc_i   (tmr_inc),
        .expire_o(tmr_expire)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        di_d    = di_q;
        data_d  = data_q;
        tmo_d   = tmo_q;
        stray_d = stray_q;
        tmr_clr = 1'b0;
        tmr_inc = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    mask_d  = cmd_mask;
                    // Response fields start cleared so a read timeout reports 0.
                    data_d  = '0;
                    tmo_d   = 1'b0;
                    if (cmd_op == 2'd1) begin
                        op_d    = OP_WRITE;
                        di_d    = cmd_wdata;
                        state_d = ST_WR_STB;
                    end else begin
                        op_d    = (cmd_op == 2'd2) ? OP_RMW : OP_READ;
                        state_d = ST_RD_STB;
                    end
                end
            end
            ST_RD_STB: begin
                tmr_clr = 1'b1;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (drp_rdy) begin
                    data_d = drp_do;
                    if (op_q == OP_RMW) begin
                        di_d    = (drp_do & ~mask_q) | (wdata_q & mask_q);
                        state_d = ST_WR_STB;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else begin
                    tmr_inc = 1'b1;
                    if (tmr_expire) begin
                        tmo_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WR_STB: begin
                tmr_clr = 1'b1;
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (drp_rdy) begin
                    state_d = ST_RESP;
                end else begin
                    tmr_inc = 1'b1;
                    if (tmr_expire) begin
                        tmo_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Only the WAIT states expect drp_rdy; a rdy on the strobe cycle
        // itself or after a timeout is unsolicited.
        if (drp_rdy && (state_q != ST_RD_WAIT) && (state_q != ST_WR_WAIT)) begin
            stray_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            di_q    <= '0;
            data_q  <= '0;
            tmo_q   <= 1'b0;
            stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            di_q    <= di_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            stray_q <= stray_d;
        end
    end

    // Gated by rst_n so cmd_ready is low throughout reset and high in the
    // very first cycle after release.
    assign cmd_ready   = rst_n && (state_q == ST_IDLE);
    assign drp_en      = (state_q == ST_RD_STB) || (state_q == ST_WR_STB);
    assign drp_we      = (state_q == ST_WR_STB);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_data    = data_q;
    assign rsp_timeout = tmo_q;
    assign drp_addr    = addr_q;
    assign drp_di      = di_q;
    assign stray_rdy   = stray_q;

endmodule

// File: tb/tb_pcie_drp_master.sv
// tb/tb_pcie_drp_master.sv - randomized self-checking bench for pcie_drp_master
module tb_pcie_drp_master;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [8:0]  cmd_addr;
    logic [15:0] cmd_wdata, cmd_mask;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_timeout;
    logic [8:0]  drp_addr;
    logic [15:0] drp_di;
    logic        drp_en, drp_we;
    logic [15:0] drp_do;
    logic        drp_rdy;
    logic        stray_rdy;

    always #5 clk = ~clk;

    pcie_drp_master #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_mask   (cmd_mask),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_timeout(rsp_timeout),
        .drp_addr   (drp_addr),
        .drp_di     (drp_di),
        .drp_en     (drp_en),
        .drp_we     (drp_we),
        .drp_do     (drp_do),
        .drp_rdy    (drp_rdy),
        .stray_rdy  (stray_rdy)
    );

    int checks   = 0;
    int failures = 0;

    // Per-cycle expectations, set by the driver from the transaction timeline.
    logic        chk_en = 1'b0;
    logic        e_cmd_ready, e_en, e_we, e_rsp_valid, e_tmo, e_stray;
    logic        chk_addr, chk_di;
    logic [8:0]  e_addr;
    logic [15:0] e_di, e_data;

    // Observations of the last transaction, pinned against literals.
    int          obs_rsp, en_cnt, we_cnt;
    logic [15:0] obs_di, obs_data;
    logic        obs_tmo;

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check1("cmd_ready", 32'(cmd_ready), 32'(e_cmd_ready));
            check1("drp_en", 32'(drp_en), 32'(e_en));
            check1("drp_we", 32'(drp_we), 32'(e_we));
            check1("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
            check1("stray_rdy", 32'(stray_rdy), 32'(e_stray));
            if (chk_addr) check1("drp_addr", 32'(drp_addr), 32'(e_addr));
            if (chk_di) check1("drp_di", 32'(drp_di), 32'(e_di));
            if (e_rsp_valid) begin
                check1("rsp_data", 32'(rsp_data), 32'(e_data));
                check1("rsp_timeout", 32'(rsp_timeout), 32'(e_tmo));
            end
        end
    end

    task automatic step(input bit stray_ev);
        @(posedge clk);
        #1;
        if (stray_ev) e_stray = 1'b1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int c = 0; c < n; c++) begin
            cmd_valid   = 1'b0;
            rsp_ready   = 1'($urandom_range(0, 1));
            drp_rdy     = rdy;
            drp_do      = 16'($urandom);
            e_cmd_ready = 1'b1;
            e_en        = 1'b0;
            e_we        = 1'b0;
            e_rsp_valid = 1'b0;
            chk_addr    = 1'b0;
            chk_di      = 1'b0;
            step(rdy);
        end
        drp_rdy = 1'b0;
    endtask

    // Timeline from handshake cycle 0: a strobe at cycle s with rdy delay d
    // completes at s+d (response at s+d+1) when d<=T, else times out with
    // the response at s+T+1. k is the read (or WRITE) delay, j the RMW write delay.
    task automatic run_txn(input int op, input logic [8:0] addr, input logic [15:0] wdata,
                           input logic [15:0] mask, input logic [15:0] rd_val,
                           input int k, input int j, input int hold);
        int rd_s, wr_s, rd_r, wr_r, resp, last, d;
        logic [15:0] di, data;
        logic tmo;
        rd_s = -1; wr_s = -1; rd_r = -1; wr_r = -1; resp = 0;
        tmo = 1'b0; data = 16'h0; di = wdata;
        if (op == 1) wr_s = 1; else rd_s = 1;
        if (rd_s > 0) begin
            if (k <= T) begin
                rd_r = rd_s + k;
                data = rd_val;
                if (op == 2) begin
                    wr_s = rd_r + 1;
                    di   = (rd_val & ~mask) | (wdata & mask);
                end else begin
                    resp = rd_r + 1;
                end
            end else begin
                tmo  = 1'b1;
                resp = rd_s + T + 1;
            end
        end
        if (wr_s > 0) begin
            d = (op == 1) ? k : j;
            if (d <= T) begin
                wr_r = wr_s + d;
                resp = wr_r + 1;
            end else begin
                tmo  = 1'b1;
                resp = wr_s + T + 1;
            end
        end
        last = resp + hold;
        obs_rsp = -1; en_cnt = 0; we_cnt = 0; obs_di = 16'h0; obs_data = 16'h0; obs_tmo = 1'b0;
        for (int c = 0; c <= last; c++) begin
            if (c == 0) begin
                cmd_valid = 1'b1; cmd_op = 2'(op); cmd_addr = addr;
                cmd_wdata = wdata; cmd_mask = mask;
            end else begin
                cmd_valid = 1'($urandom_range(0, 1)); cmd_op = 2'($urandom);
                cmd_addr = 9'($urandom); cmd_wdata = 16'($urandom); cmd_mask = 16'($urandom);
            end
            drp_rdy     = (c == rd_r) || (c == wr_r);
            drp_do      = (c == rd_r) ? rd_val : 16'($urandom);
            rsp_ready   = (c < resp) ? 1'($urandom_range(0, 1)) : (c == last);
            e_cmd_ready = (c == 0);
            e_en        = (c == rd_s) || (c == wr_s);
            e_we        = (c == wr_s);
            e_rsp_valid = (c >= resp);
            chk_addr    = (c >= 1);
            e_addr      = addr;
            chk_di      = (wr_s > 0) && (c >= wr_s);
            e_di        = di;
            e_data      = data;
            e_tmo       = tmo;
            @(negedge clk);
            if (rsp_valid && obs_rsp < 0) obs_rsp = c;
            if (drp_en) en_cnt++;
            if (drp_en && drp_we) begin
                we_cnt++;
                obs_di = drp_di;
            end
            if (rsp_valid) begin
                obs_data = rsp_data;
                obs_tmo  = rsp_timeout;
            end
            step(1'b0);
        end
        cmd_valid = 1'b0;
        drp_rdy   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        check1({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
        check1({tag, "_drp_en"}, 32'(drp_en), 0);
        check1({tag, "_drp_we"}, 32'(drp_we), 0);
        check1({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check1({tag, "_rsp_data"}, 32'(rsp_data), 0);
        check1({tag, "_rsp_timeout"}, 32'(rsp_timeout), 0);
        check1({tag, "_drp_addr"}, 32'(drp_addr), 0);
        check1({tag, "_drp_di"}, 32'(drp_di), 0);
        check1({tag, "_stray_rdy"}, 32'(stray_rdy), 0);
    endtask

    int r_op, r_k, r_j, r_hold;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 9'h0;
        cmd_wdata = 16'h0; cmd_mask = 16'h0; rsp_ready = 1'b0; drp_do = 16'h0; drp_rdy = 1'b0;
        e_cmd_ready = 1'b0; e_en = 1'b0; e_we = 1'b0; e_rsp_valid = 1'b0; e_tmo = 1'b0;
        e_stray = 1'b0; chk_addr = 1'b0; chk_di = 1'b0; e_addr = 9'h0; e_di = 16'h0; e_data = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(2, 1'b0);

        run_txn(1, 9'h004, 16'h0123, 16'h0000, 16'h0000, 3, 0, 0);
        check1("wr_rsp_cycle", 32'(obs_rsp), 5);
        check1("wr_strobes", 32'(en_cnt), 1);
        check1("wr_we_strobes", 32'(we_cnt), 1);
        check1("wr_di", 32'(obs_di), 32'h0123);
        check1("wr_timeout", 32'(obs_tmo), 0);

        run_txn(0, 9'h1FF, 16'h0000, 16'h0000, 16'hBEEF, 1, 0, 0);
        check1("rd_rsp_cycle", 32'(obs_rsp), 3);
        check1("rd_data", 32'(obs_data), 32'hBEEF);
        check1("rd_strobes", 32'(en_cnt), 1);
        check1("rd_we_strobes", 32'(we_cnt), 0);

        run_txn(2, 9'h010, 16'h1234, 16'h00FF, 16'hF0F0, 2, 1, 0);
        check1("rmw_di", 32'(obs_di), 32'hF034);
        check1("rmw_data", 32'(obs_data), 32'hF0F0);
        check1("rmw_strobes", 32'(en_cnt), 2);
        check1("rmw_rsp_cycle", 32'(obs_rsp), 6);

        run_txn(0, 9'h033, 16'h0000, 16'h0000, 16'h5555, 99, 0, 0);
        check1("tmo_rsp_cycle", 32'(obs_rsp), 10);
        check1("tmo_flag", 32'(obs_tmo), 1);
        check1("tmo_data", 32'(obs_data), 0);
        idle(1, 1'b1);
        idle(1, 1'b0);
        check1("stray_after_late_rdy", 32'(stray_rdy), 1);

        run_txn(3, 9'h0C3, 16'h0000, 16'h0000, 16'hA5A5, 2, 0, 0);
        check1("reserved_op_data", 32'(obs_data), 32'hA5A5);
        check1("reserved_op_strobes", 32'(en_cnt), 1);

        run_txn(0, 9'h021, 16'h0000, 16'h0000, 16'h1357, T, 0, 0);
        check1("last_wait_cycle_tmo", 32'(obs_tmo), 0);
        check1("last_wait_cycle_rsp", 32'(obs_rsp), T + 2);

        run_txn(2, 9'h022, 16'hFFFF, 16'hFF00, 16'h00AA, 2, 99, 0);
        check1("rmw_wr_tmo_flag", 32'(obs_tmo), 1);
        check1("rmw_wr_tmo_data", 32'(obs_data), 32'h00AA);
        check1("rmw_wr_tmo_di", 32'(obs_di), 32'hFFAA);

        run_txn(0, 9'h0F0, 16'h0000, 16'h0000, 16'h2468, 2, 0, 5);
        check1("hold_rsp_cycle", 32'(obs_rsp), 4);
        check1("hold_strobes", 32'(en_cnt), 1);
        idle(1, 1'b0);

        // Reset while waiting for the read rdy.
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 9'h0AA; rsp_ready = 1'b1; drp_rdy = 1'b0;
        e_cmd_ready = 1'b1; e_en = 1'b0; e_we = 1'b0; e_rsp_valid = 1'b0; chk_addr = 1'b0; chk_di = 1'b0;
        step(1'b0);
        cmd_valid = 1'b0; e_cmd_ready = 1'b0; e_en = 1'b1; chk_addr = 1'b1; e_addr = 9'h0AA;
        step(1'b0);
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        e_stray = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        run_txn(1, 9'h155, 16'hCAFE, 16'h0000, 16'h0000, 2, 0, 0);
        check1("post_reset_rsp_cycle", 32'(obs_rsp), 4);
        check1("post_reset_strobes", 32'(en_cnt), 1);
        idle(1, 1'b1);
        idle(1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            r_op   = int'($urandom_range(0, 3));
            r_k    = ($urandom_range(0, 5) == 0) ? T + 3 : int'($urandom_range(1, T));
            r_j    = ($urandom_range(0, 5) == 0) ? T + 3 : int'($urandom_range(1, T));
            r_hold = int'($urandom_range(0, 3));
            run_txn(r_op, 9'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), r_k, r_j, r_hold);
            idle(int'($urandom_range(0, 2)), 1'b0);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pcie_drp_master.md
# pcie_drp_master

Sequencer that owns the DRP port of the PCIE_2_1 hard block. It accepts read, write and read-modify-write commands over a valid/ready interface and issues single-cycle DRPEN/DRPWE strobes. It waits for DRPRDY under a timeout and returns read data plus a status on a valid/ready response channel. It sits directly upstream of the PCIE_2_1 DRP pins (DRPADDR/DRPDI/DRPEN/DRPWE in, DRPDO/DRPRDY out) and shares the DRP clock with them.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: cycles to wait for drp_rdy after a strobe before declaring a timeout; legal range 2..1023.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  DRP clock, also drives PCIE_2_1 DRPCLK
- rst_n  in  1  async active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_op  in  2  0=READ, 1=WRITE, 2=RMW, 3=reserved (treated as READ)
- cmd_addr  in  9  DRP address
- cmd_wdata  in  16  write data
- cmd_mask  in  16  RMW bit mask; 1 = take cmd_wdata bit
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when both high
- rsp_data  out  16  read data (READ/RMW = value read before modify); 0 for WRITE
- rsp_timeout  out  1  access timed out
- drp_addr  out  9  to DRPADDR
- drp_di  out  16  to DRPDI
- drp_en  out  1  to DRPEN
- drp_we  out  1  to DRPWE
- drp_do  in  16  from DRPDO
- drp_rdy  in  1  from DRPRDY
- stray_rdy  out  1  sticky; drp_rdy seen while no access outstanding

## Operation
- States: IDLE, RD_STB, RD_WAIT, WR_STB, WR_WAIT, RESP.
- IDLE: cmd_ready=1. On handshake, latch op/addr/wdata/mask.
  - READ/RMW go to RD_STB.
  - WRITE goes to WR_STB with drp_di=cmd_wdata.
- RD_STB: drp_en=1, drp_we=0 for exactly one cycle; go to RD_WAIT.
- RD_WAIT: on drp_rdy, capture drp_do into rsp_data.
  - READ goes to RESP.
  - RMW computes drp_di=(drp_do & ~mask) | (wdata & mask) and goes to WR_STB.
- WR_STB: drp_en=1, drp_we=1 for exactly one cycle; go to WR_WAIT.
- WR_WAIT: on drp_rdy, go to RESP.
- RESP: rsp_valid=1, with rsp_data/rsp_timeout stable until rsp_ready; then go to IDLE.
- Timeout: the counter clears on every strobe and increments each WAIT cycle without drp_rdy.
  - When it reaches TIMEOUT_CYCLES, set rsp_timeout=1 and go to RESP.
  - An RMW that times out on its read does not issue the write; rsp_data=0.
- drp_addr is held stable from the strobe until the state returns to IDLE. drp_di is held from WR_STB to IDLE.
- stray_rdy: set when drp_rdy=1 in IDLE, STB or RESP states. This includes a late rdy after a timeout. It clears only on reset.

## Timing
- Reset values: cmd_ready=0 during reset, 1 in the first cycle after deassertion. All other outputs are 0 and the state is IDLE.
- drp_rdy is sampled only from the cycle after the strobe. A rdy coincident with the strobe counts as stray.
- READ, with rdy k≥1 cycles after the strobe: cmd handshake at cycle 0, drp_en at cycle 1, rdy at cycle 1+k, rsp_valid at cycle 2+k.
- WRITE: same as READ with drp_we=1.
- RMW: read rdy at cycle 1+k, write strobe at cycle 2+k, write rdy at cycle 2+k+j, rsp_valid at cycle 3+k+j.
- Timeout: rsp_valid appears TIMEOUT_CYCLES+2 cycles after the handshake.
- With rsp_ready held high, back-to-back throughput is one command per 3+k cycles for READ/WRITE. The next cmd_ready comes in the cycle after the rsp handshake.
- Reset mid-operation abandons the access and produces no response. A rdy that arrives after reset sets stray_rdy.

## Structure
- Package pcie_drp_pkg holds:
  - DRP_ADDR_W=9 and DRP_DATA_W=16
  - the op enum (OP_READ, OP_WRITE, OP_RMW)
  - the state enum.
- One natural sub-module is pcie_drp_timer, a clearable saturating counter with a terminal flag, width clog2(TIMEOUT_CYCLES+1). Everything else is flat.

## Test plan
- WRITE addr 0x004, data 0x0123, rdy 3 cycles after the strobe → one strobe with en=we=1, addr=0x004, di=0x0123; rsp_valid at cycle 5; rsp_timeout=0.
- READ addr 0x1FF, drp_do=0xBEEF, rdy after 1 cycle → rsp_data=0xBEEF at cycle 3; exactly one drp_en pulse.
- RMW addr 0x010, read 0xF0F0, mask 0x00FF, wdata 0x1234 → write strobe with di=0xF034; rsp_data=0xF0F0.
- READ with rdy never asserted, TIMEOUT_CYCLES=8 → rsp_timeout=1 and rsp_data=0 at cycle 10. A later rdy sets stray_rdy, and the next command works normally.
- Hold rsp_ready=0 for 5 cycles → rsp fields stable, cmd_ready=0, no extra DRP strobes. On release, cmd_ready=1 in the next cycle.
- Assert rst_n=0 during RD_WAIT → all outputs 0 immediately. After release there is no response, and the command can be accepted in the first cycle.
